// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, FUNCT3 codes, TYPES bit
// positions and the legality/alignment rules applied to an incoming access.
package load_store_unit_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned T_LOAD  = 4;
  localparam int unsigned T_STORE = 3;

  localparam int unsigned ACK_TIMEOUT_DEF = 255;

  // Access classes and FUNCT3 codes the unit cannot execute.
  function automatic logic is_illegal(input logic is_load, input logic is_store,
                                      input logic [2:0] f3);
    logic bad_load;
    logic bad_store;
    bad_load  = is_load && ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
    bad_store = is_store && (f3 >= 3'b011);
    return (is_load && is_store) || bad_load || bad_store;
  endfunction

  // FUNCT3[1:0] encodes access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Extracts and extends the addressed byte/halfword/word from a read data word.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data_c
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = w_shifted[15:0];
    o_data_c  = i_rdata;
    case (i_funct3)
      F3_LB:   o_data_c = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data_c = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data_c = i_rdata;
      F3_LBU:  o_data_c = {24'd0, w_byte};
      F3_LHU:  o_data_c = {16'd0, w_half};
      default: o_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data-memory access with writeback, alignment
// checking and an ACK timeout; non-memory operations pass straight to writeback.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ex_valid,
  output logic                  o_ex_ready,
  input  logic [DATA_WIDTH-1:0] i_alu_out_in,
  input  logic [DATA_WIDTH-1:0] i_rs2_in,
  input  logic [2:0]            i_funct3,
  input  logic [6:0]            i_types,
  input  logic [4:0]            i_rd_in,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [3:0]            o_dmem_be,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic                  i_dmem_ack,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic                  o_wb_valid,
  output logic                  o_wb_en,
  output logic [4:0]            o_wb_rd,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  output logic                  o_fault
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  lsu_state_e            r_state;
  logic                  r_ex_ready;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dmem_req;
  logic                  r_dmem_we;
  logic [DATA_WIDTH-1:0] r_dmem_addr;
  logic [3:0]            r_dmem_be;
  logic [DATA_WIDTH-1:0] r_dmem_wdata;
  logic                  r_wb_valid;
  logic                  r_wb_en;
  logic [4:0]            r_wb_rd;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_fault;
  logic                  r_is_load;
  logic [4:0]            r_rd;
  logic [2:0]            r_funct3;
  logic [1:0]            r_addr_lo;

  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_bad;
  logic [1:0]            w_addr_lo;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_unused;

  assign w_is_load  = i_types[T_LOAD];
  assign w_is_store = i_types[T_STORE];
  assign w_addr_lo  = i_alu_out_in[1:0];
  assign w_bad      = is_illegal(w_is_load, w_is_store, i_funct3) ||
                      is_misaligned(i_funct3, w_addr_lo);
  assign w_unused   = ^{i_types[6:5], i_types[2:0]};

  // Byte lanes and replicated write data for the incoming access.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_rs2_in;
    case (i_funct3[1:0])
      2'b00: begin
        w_be    = 4'(4'b0001 << w_addr_lo);
        w_wdata = {4{i_rs2_in[7:0]}};
      end
      2'b01: begin
        w_be    = 4'(4'b0011 << w_addr_lo);
        w_wdata = {2{i_rs2_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_rs2_in;
      end
    endcase
  end

  load_align u_load_align (
    .i_rdata   (i_dmem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data_c  (w_load_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_ex_ready   <= 1'b1;
      r_cnt        <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_be    <= '0;
      r_dmem_wdata <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_en      <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_fault      <= 1'b0;
      r_is_load    <= 1'b0;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_addr_lo    <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_en    <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_ex_valid) begin
            r_wb_rd <= i_rd_in;
            if (!w_is_load && !w_is_store) begin
              r_wb_valid <= 1'b1;
              r_wb_en    <= (i_rd_in != 5'd0);
              r_wb_data  <= i_alu_out_in;
            end else if (w_bad) begin
              r_wb_valid <= 1'b1;
              r_fault    <= 1'b1;
              r_wb_data  <= '0;
            end else begin
              r_state      <= ST_REQ;
              r_ex_ready   <= 1'b0;
              r_cnt        <= '0;
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= w_is_store;
              r_dmem_addr  <= {i_alu_out_in[DATA_WIDTH-1:2], 2'b00};
              r_dmem_be    <= w_be;
              r_dmem_wdata <= w_wdata;
              r_is_load    <= w_is_load;
              r_rd         <= i_rd_in;
              r_funct3     <= i_funct3;
              r_addr_lo    <= w_addr_lo;
            end
          end
        end
        ST_REQ: begin
          // ACK takes priority over a timeout landing in the same cycle.
          if (i_dmem_ack) begin
            r_state    <= ST_IDLE;
            r_ex_ready <= 1'b1;
            r_dmem_req <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_en    <= r_is_load && (r_rd != 5'd0);
            r_wb_data  <= r_is_load ? w_load_data : '0;
          end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            r_state    <= ST_IDLE;
            r_ex_ready <= 1'b1;
            r_dmem_req <= 1'b0;
            r_wb_valid <= 1'b1;
            r_fault    <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ex_ready <= 1'b1;
          r_dmem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_ex_ready   = r_ex_ready;
  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_be    = r_dmem_be;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_wb_valid   = r_wb_valid;
  assign o_wb_en      = r_wb_en;
  assign o_wb_rd      = r_wb_rd;
  assign o_wb_data    = r_wb_data;
  assign o_fault      = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

  localparam logic [6:0] TY_R = 7'b1000000;
  localparam logic [6:0] TY_I = 7'b0100000;
  localparam logic [6:0] TY_L = 7'b0010000;
  localparam logic [6:0] TY_S = 7'b0001000;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu;
  logic [31:0] rs2;
  logic [2:0]  funct3;
  logic [6:0]  types;
  logic [4:0]  rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.DATA_WIDTH(32), .ACK_TIMEOUT(TIMEOUT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ex_valid   (ex_valid),
    .o_ex_ready   (ex_ready),
    .i_alu_out_in (alu),
    .i_rs2_in     (rs2),
    .i_funct3     (funct3),
    .i_types      (types),
    .i_rd_in      (rd),
    .o_dmem_req   (dmem_req),
    .o_dmem_we    (dmem_we),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_be    (dmem_be),
    .o_dmem_wdata (dmem_wdata),
    .i_dmem_ack   (dmem_ack),
    .i_dmem_rdata (dmem_rdata),
    .o_wb_valid   (wb_valid),
    .o_wb_en      (wb_en),
    .o_wb_rd      (wb_rd),
    .o_wb_data    (wb_data),
    .o_fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] ty, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r);
    ex_valid = 1'b1;
    types    = ty;
    funct3   = f3;
    alu      = a;
    rs2      = d;
    rd       = r;
  endtask

  // Reference: value a load returns, from size/sign rules on the addressed bytes.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    longint unsigned shifted;
    longint unsigned range;
    longint unsigned v;
    shifted = longint'(word) / (longint'(1) << (8 * (a % 4)));
    range   = (f3 % 4 == 0) ? 256 : (f3 % 4 == 1) ? 65536 : 64'h1_0000_0000;
    v       = shifted % range;
    if (f3 < 4 && v >= range / 2) v = v + 64'h1_0000_0000 - range;
    return 32'(v);
  endfunction

  // Issues one op, waits delay REQ cycles before ACK, checks all visible results.
  task automatic run_op(input string tag, input logic [6:0] ty, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                        input int delay, input logic [31:0] word);
    bit is_l, is_s, bad;
    int size;
    logic [31:0] exp_be, exp_wd;
    is_l = ty[4];
    is_s = ty[3];
    size = 1 << (f3 % 4);
    bad  = (is_l && is_s) || (is_l && (f3 == 3 || f3 == 6 || f3 == 7)) ||
           (is_s && f3 >= 3) || (a % size != 0);
    drive(ty, f3, a, d, r);
    step();
    ex_valid = 1'b0;
    if (!is_l && !is_s) begin
      chk({tag, ".wbv"}, 32'(wb_valid), 32'd1);
      chk({tag, ".data"}, wb_data, a);
      chk({tag, ".en"}, 32'(wb_en), 32'(r != 0));
      chk({tag, ".flt"}, 32'(fault), 32'd0);
      chk({tag, ".rd"}, 32'(wb_rd), 32'(r));
    end else if (bad) begin
      chk({tag, ".bad.req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".bad.wbv"}, 32'(wb_valid), 32'd1);
      chk({tag, ".bad.flt"}, 32'(fault), 32'd1);
      chk({tag, ".bad.en"}, 32'(wb_en), 32'd0);
    end else begin
      exp_be = 32'(((1 << size) - 1) << (a % 4));
      exp_wd = (size == 1) ? (d % 256) * 32'h0101_0101 :
               (size == 2) ? (d % 65536) * 32'h0001_0001 : d;
      chk({tag, ".req"}, 32'(dmem_req), 32'd1);
      chk({tag, ".addr"}, dmem_addr, a - (a % 4));
      chk({tag, ".we"}, 32'(dmem_we), 32'(is_s));
      chk({tag, ".be"}, 32'(dmem_be), exp_be);
      if (is_s) chk({tag, ".wdata"}, dmem_wdata, exp_wd);
      for (int i = 0; i < delay; i++) begin
        chk({tag, ".hold"}, {30'd0, dmem_req, ex_ready}, 32'd2);
        step();
      end
      dmem_ack   = 1'b1;
      dmem_rdata = word;
      step();
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      chk({tag, ".done.req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".wbv"}, 32'(wb_valid), 32'd1);
      chk({tag, ".flt"}, 32'(fault), 32'd0);
      chk({tag, ".en"}, 32'(wb_en), 32'(is_l && r != 0));
      if (is_l) chk({tag, ".ldata"}, wb_data, model_load(f3, a, word));
    end
    step();
    chk({tag, ".pulse"}, {30'd0, wb_valid, ex_ready}, 32'd1);
  endtask

  initial begin
    int n;
    logic [6:0] ty;
    rst = 1'b1; ex_valid = 1'b0; types = TY_R; funct3 = 3'd0; alu = '0; rs2 = '0; rd = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #1;
    chk("rst.bus", {dmem_req, dmem_we, dmem_be, 26'd0}, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.wb", {wb_valid, wb_en, fault, wb_rd, 24'd0}, 32'd0);
    chk("rst.wbdata", wb_data, 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("rst.ready", 32'(ex_ready), 32'd1);

    // Back-to-back non-memory ops.
    drive(TY_R, 3'd0, 32'h11, 32'h0, 5'd5);
    step();
    drive(TY_R, 3'd0, 32'h22, 32'h0, 5'd0);
    chk("b2b.v1", {wb_valid, wb_en, 30'd0}, 32'hC000_0000);
    chk("b2b.d1", wb_data, 32'h11);
    step();
    ex_valid = 1'b0;
    chk("b2b.v2", {wb_valid, wb_en, 30'd0}, 32'h8000_0000);
    chk("b2b.d2", wb_data, 32'h22);
    step();
    chk("b2b.end", 32'(wb_valid), 32'd0);

    run_op("lb", TY_L, 3'b000, 32'h1003, 32'h0, 5'd7, 2, 32'h80FF_0000);
    chk("lb.exact", wb_data, 32'hFFFF_FF80);
    run_op("lbu", TY_L, 3'b100, 32'h1003, 32'h0, 5'd7, 2, 32'h80FF_0000);
    chk("lbu.exact", wb_data, 32'h0000_0080);
    run_op("sh", TY_S, 3'b001, 32'h2002, 32'h1234_ABCD, 5'd3, 1, 32'h0);
    run_op("lw.mis", TY_L, 3'b010, 32'h0001, 32'h0, 5'd4, 0, 32'h0);
    run_op("both", TY_L | TY_S, 3'b010, 32'h0, 32'h0, 5'd4, 0, 32'h0);
    run_op("sb.f3", TY_S, 3'b100, 32'h0, 32'h0, 5'd4, 0, 32'h0);

    // ACK while idle has no effect.
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("idle.ack", {30'd0, wb_valid, dmem_req}, 32'd0);

    // Timeout with no ACK.
    drive(TY_L, 3'b010, 32'h40, 32'h0, 5'd9);
    step();
    ex_valid = 1'b0;
    n = 0;
    while (dmem_req && n < 400) begin n++; step(); end
    chk("to.cycles", 32'(n), 32'(TIMEOUT));
    chk("to.wb", {wb_valid, fault, wb_en, dmem_req, 28'd0}, 32'hC000_0000);

    // ACK in the final allowed cycle beats the timeout.
    run_op("to.edge", TY_L, 3'b010, 32'h44, 32'h0, 5'd9, TIMEOUT - 1, 32'hCAFE_F00D);

    // Reset while waiting abandons the access.
    drive(TY_L, 3'b010, 32'h80, 32'h0, 5'd2);
    step();
    ex_valid = 1'b0;
    repeat (9) step();
    chk("rr.req", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rr.async", {30'd0, dmem_req, wb_valid}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rr.ready", {29'd0, ex_ready, wb_valid, dmem_req}, 32'd4);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("rr.quiet", {30'd0, wb_valid, dmem_req}, 32'd0);

    // Randomized mix.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: ty = TY_R;
        1: ty = TY_I;
        2: ty = TY_L;
        default: ty = TY_S;
      endcase
      run_op("rand", ty, 3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 4), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
